// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the ARM-subset multi-cycle controller: FSM states,
// ALU/immediate selects, instruction field codes and condition codes.
package arm_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH  = 4'd0;
  localparam state_t S_DECODE = 4'd1;
  localparam state_t S_EXEC   = 4'd2;
  localparam state_t S_ALUWB  = 4'd3;
  localparam state_t S_MEMADR = 4'd4;
  localparam state_t S_MEMRD  = 4'd5;
  localparam state_t S_MEMWB  = 4'd6;
  localparam state_t S_MEMWR  = 4'd7;
  localparam state_t S_BRANCH = 4'd8;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] IMM_8  = 2'b00;
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_24 = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  function automatic logic [1:0] cmd_to_alu(input logic [3:0] cmd);
    case (cmd)
      CMD_SUB, CMD_CMP: return ALU_SUB;
      CMD_AND:          return ALU_AND;
      CMD_ORR:          return ALU_ORR;
      default:          return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluator against registered {N,Z,C,V}; purely combinational.
module cond_check
  import arm_ctrl_pkg::*;
#(
  parameter int COND_EN = 1
) (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;
  logic eval;

  assign {n, z, c, v} = flags;

  always_comb begin
    eval = 1'b0;
    case (cond)
      COND_EQ: eval = z;
      COND_NE: eval = !z;
      COND_CS: eval = c;
      COND_CC: eval = !c;
      COND_MI: eval = n;
      COND_PL: eval = !n;
      COND_VS: eval = v;
      COND_VC: eval = !v;
      COND_HI: eval = c && !z;
      COND_LS: eval = !c || z;
      COND_GE: eval = (n == v);
      COND_LT: eval = (n != v);
      COND_GT: eval = !z && (n == v);
      COND_LE: eval = z || (n != v);
      COND_AL: eval = 1'b1;
      default: eval = 1'b0;   // 1111 is rejected as illegal by the decoder
    endcase
  end

  assign pass = (COND_EN == 0) ? 1'b1 : eval;

endmodule

// File: rtl/arm_mc_control.sv
// Multi-cycle FSM controller for the ARM-subset datapath: decodes the IR,
// gates each instruction on its condition code and owns the NZCV register.
module arm_mc_control
  import arm_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 2,
  parameter int IMMSRC_W  = 2,
  parameter int COND_EN   = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [31:0]          Instr,
  input  logic                 Z,
  input  logic                 N,
  input  logic                 C,
  input  logic                 V,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic                 PCSrc,
  output logic [1:0]           RegSrc,
  output logic                 RegWrite,
  output logic                 ALUSrc,
  output logic                 MemWrite,
  output logic                 MemtoReg,
  output logic [IMMSRC_W-1:0]  ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [3:0]           flags,
  output logic                 illegal
);

  state_t     state_reg, state_next;
  logic [3:0] flags_reg;

  logic [3:0] cond, cmd;
  logic [1:0] op;
  logic       ibit, sbit, ubit;
  logic       unused_bits;

  assign cond = Instr[31:28];
  assign op   = Instr[27:26];
  assign ibit = Instr[25];
  assign cmd  = Instr[24:21];
  assign ubit = Instr[23];
  assign sbit = Instr[20];
  assign unused_bits = ^Instr[19:0];

  logic dp_ok, is_cmp, is_logic, legal, cond_pass, flag_we;
  logic [1:0] dp_alu, regsrc_dec;

  assign dp_ok    = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) ||
                    (cmd == CMD_ORR) || (cmd == CMD_CMP);
  assign is_cmp   = (cmd == CMD_CMP);
  assign is_logic = (cmd == CMD_AND) || (cmd == CMD_ORR);
  assign flag_we  = sbit || is_cmp;
  assign dp_alu   = cmd_to_alu(cmd);
  assign legal    = !((COND_EN != 0) && (cond == COND_NV)) &&
                    (((op == OP_DP) && dp_ok) || (op == OP_MEM) || (op == OP_BR));
  // RegSrc[1]: STR reads Rd as the store data; RegSrc[0]: branch reads PC
  assign regsrc_dec = {(op == OP_MEM) && !sbit, op == OP_BR};

  cond_check #(.COND_EN(COND_EN)) u_cond (
    .cond  (cond),
    .flags (flags_reg),
    .pass  (cond_pass)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        if (!legal || !cond_pass) state_next = S_FETCH;
        else if (op == OP_DP)     state_next = S_EXEC;
        else if (op == OP_MEM)    state_next = S_MEMADR;
        else                      state_next = S_BRANCH;
      end
      S_EXEC:   state_next = S_ALUWB;
      S_MEMADR: state_next = sbit ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg <= S_FETCH;
      flags_reg <= 4'b0000;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_ALUWB && flag_we)
        flags_reg <= is_logic ? {N, Z, flags_reg[1:0]} : {N, Z, C, V};
    end
  end

  logic       pcwrite_c, irwrite_c, adrsrc_c, pcsrc_c, regwrite_c;
  logic       alusrc_c, memwrite_c, memtoreg_c, illegal_c;
  logic [1:0] regsrc_c, immsrc_c, aluctl_c;

  always_comb begin
    pcwrite_c  = 1'b0;
    irwrite_c  = 1'b0;
    adrsrc_c   = 1'b0;
    pcsrc_c    = 1'b0;
    regwrite_c = 1'b0;
    alusrc_c   = 1'b0;
    memwrite_c = 1'b0;
    memtoreg_c = 1'b0;
    illegal_c  = 1'b0;
    immsrc_c   = IMM_8;
    aluctl_c   = ALU_ADD;
    regsrc_c   = (state_reg == S_FETCH) ? 2'b00 : regsrc_dec;
    case (state_reg)
      S_FETCH: begin
        irwrite_c = mem_ready;
        pcwrite_c = mem_ready;
      end
      S_DECODE: illegal_c = !legal;
      // ALU controls stay up through ALUWB so the sampled flags belong to this op
      S_EXEC, S_ALUWB: begin
        alusrc_c   = ibit;
        aluctl_c   = dp_alu;
        regwrite_c = (state_reg == S_ALUWB) && !is_cmp;
      end
      S_MEMADR: begin
        alusrc_c = 1'b1;
        immsrc_c = IMM_12;
        aluctl_c = ubit ? ALU_ADD : ALU_SUB;
      end
      S_MEMRD: adrsrc_c = 1'b1;
      S_MEMWB: begin
        memtoreg_c = 1'b1;
        regwrite_c = 1'b1;
      end
      S_MEMWR: begin
        adrsrc_c   = 1'b1;
        memwrite_c = 1'b1;
      end
      S_BRANCH: begin
        immsrc_c  = IMM_24;
        alusrc_c  = 1'b1;
        pcsrc_c   = 1'b1;
        pcwrite_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Everything is forced low while reset is asserted, so an aborted access writes nothing
  assign PCWrite    = reset_n && pcwrite_c;
  assign IRWrite    = reset_n && irwrite_c;
  assign AdrSrc     = reset_n && adrsrc_c;
  assign PCSrc      = reset_n && pcsrc_c;
  assign RegSrc     = reset_n ? regsrc_c : 2'b00;
  assign RegWrite   = reset_n && regwrite_c;
  assign ALUSrc     = reset_n && alusrc_c;
  assign MemWrite   = reset_n && memwrite_c;
  assign MemtoReg   = reset_n && memtoreg_c;
  assign ImmSrc     = reset_n ? IMMSRC_W'(immsrc_c) : '0;
  assign ALUControl = reset_n ? ALUCTRL_W'(aluctl_c) : '0;
  assign illegal    = reset_n && illegal_c;
  assign flags      = flags_reg;

endmodule

// File: tb/tb_arm_mc_control.sv
// Directed table-driven bench for arm_mc_control: one row per clock cycle.
module tb_arm_mc_control;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] Instr = 32'h0;
  logic        Z = 1'b0, N = 1'b0, C = 1'b0, V = 1'b0;
  logic        mem_ready = 1'b0;
  logic        PCWrite, IRWrite, AdrSrc, PCSrc, RegWrite, ALUSrc, MemWrite, MemtoReg, illegal;
  logic [1:0]  RegSrc, ImmSrc, ALUControl;
  logic [3:0]  flags;

  always #5 clock = ~clock;

  arm_mc_control dut (
    .clock(clock), .reset_n(reset_n), .Instr(Instr),
    .Z(Z), .N(N), .C(C), .V(V), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .PCSrc(PCSrc),
    .RegSrc(RegSrc), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .flags(flags), .illegal(illegal)
  );

  typedef struct {
    string       name;
    logic        rst_n;
    logic [31:0] instr;
    logic        rdy;
    logic [3:0]  nzcv;
    logic [14:0] ectl;
    logic [3:0]  eflags;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // {PCWrite,IRWrite,AdrSrc,PCSrc,RegSrc,RegWrite,ALUSrc,MemWrite,MemtoReg,ImmSrc,ALUControl,illegal}
  function automatic logic [14:0] ctl(input logic pcw, input logic irw, input logic adr,
                                      input logic pcs, input logic [1:0] rs, input logic rw,
                                      input logic as, input logic mw, input logic m2r,
                                      input logic [1:0] imm, input logic [1:0] alu,
                                      input logic ill);
    return {pcw, irw, adr, pcs, rs, rw, as, mw, m2r, imm, alu, ill};
  endfunction

  task automatic add(input string name, input logic rst_n, input logic [31:0] instr,
                     input logic rdy, input logic [3:0] nzcv, input logic [14:0] ectl,
                     input logic [3:0] eflags);
    vec_t v;
    v.name = name; v.rst_n = rst_n; v.instr = instr; v.rdy = rdy;
    v.nzcv = nzcv; v.ectl = ectl; v.eflags = eflags;
    tbl.push_back(v);
  endtask

  task automatic step(input vec_t v);
    logic [14:0] got;
    @(negedge clock);
    reset_n = v.rst_n;
    Instr = v.instr;
    mem_ready = v.rdy;
    {N, Z, C, V} = v.nzcv;
    #1;
    got = {PCWrite, IRWrite, AdrSrc, PCSrc, RegSrc, RegWrite, ALUSrc, MemWrite,
           MemtoReg, ImmSrc, ALUControl, illegal};
    n_cmp++;
    if ({got, flags} !== {v.ectl, v.eflags}) begin
      n_bad++;
      $display("FAIL %s: got ctl=%b flags=%b, need ctl=%b flags=%b",
               v.name, got, flags, v.ectl, v.eflags);
    end else begin
      $display("ok   %s: ctl=%b flags=%b", v.name, got, flags);
    end
  endtask

  localparam logic [31:0] I_ADD   = 32'hE0821003;
  localparam logic [31:0] I_SUBS  = 32'hE2511001;
  localparam logic [31:0] I_BNE   = 32'h1AFFFFFE;
  localparam logic [31:0] I_B     = 32'hEA000001;
  localparam logic [31:0] I_LDR   = 32'hE5912004;
  localparam logic [31:0] I_STR   = 32'hE5012004;
  localparam logic [31:0] I_CMP   = 32'hE1510002;
  localparam logic [31:0] I_ANDS  = 32'hE0112003;
  localparam logic [31:0] I_ILL   = 32'hEC000000;
  localparam logic [31:0] I_ADDGT = 32'hC0821003;
  localparam logic [31:0] I_ORR   = 32'hE3811001;

  logic [14:0] fet, none;

  initial begin
    fet  = ctl(1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    none = '0;

    add("reset",        0, I_ADD,  1, 4'h0, none, 4'b0000);
    add("add.fetch",    1, I_ADD,  1, 4'h0, fet,  4'b0000);
    add("add.decode",   1, I_ADD,  1, 4'h0, none, 4'b0000);
    add("add.exec",     1, I_ADD,  1, 4'h0, none, 4'b0000);
    add("add.aluwb",    1, I_ADD,  1, 4'hF, ctl(0,0,0,0,2'b00,1,0,0,0,2'b00,2'b00,0), 4'b0000);
    add("subs.fetch",   1, I_SUBS, 1, 4'h0, fet,  4'b0000);
    add("subs.decode",  1, I_SUBS, 1, 4'h0, none, 4'b0000);
    add("subs.exec",    1, I_SUBS, 1, 4'h0, ctl(0,0,0,0,2'b00,0,1,0,0,2'b00,2'b01,0), 4'b0000);
    add("subs.aluwb",   1, I_SUBS, 1, 4'b0100, ctl(0,0,0,0,2'b00,1,1,0,0,2'b00,2'b01,0), 4'b0000);
    add("bne.fetch",    1, I_BNE,  1, 4'h0, fet,  4'b0100);
    add("bne.decode",   1, I_BNE,  1, 4'h0, ctl(0,0,0,0,2'b01,0,0,0,0,2'b00,2'b00,0), 4'b0100);
    add("b.fetch",      1, I_B,    1, 4'h0, fet,  4'b0100);
    add("b.decode",     1, I_B,    1, 4'h0, ctl(0,0,0,0,2'b01,0,0,0,0,2'b00,2'b00,0), 4'b0100);
    add("b.branch",     1, I_B,    1, 4'h0, ctl(1,0,0,1,2'b01,0,1,0,0,2'b10,2'b00,0), 4'b0100);
    add("ldr.fetch",    1, I_LDR,  1, 4'h0, fet,  4'b0100);
    add("ldr.decode",   1, I_LDR,  1, 4'h0, none, 4'b0100);
    add("ldr.memadr",   1, I_LDR,  1, 4'h0, ctl(0,0,0,0,2'b00,0,1,0,0,2'b01,2'b00,0), 4'b0100);
    for (int k = 0; k < 3; k++)
      add($sformatf("ldr.memrd.wait%0d", k), 1, I_LDR, 0, 4'h0,
          ctl(0,0,1,0,2'b00,0,0,0,0,2'b00,2'b00,0), 4'b0100);
    add("ldr.memrd.rdy", 1, I_LDR, 1, 4'h0, ctl(0,0,1,0,2'b00,0,0,0,0,2'b00,2'b00,0), 4'b0100);
    add("ldr.memwb",    1, I_LDR,  1, 4'h0, ctl(0,0,0,0,2'b00,1,0,0,1,2'b00,2'b00,0), 4'b0100);
    add("str.fetch.wait", 1, I_STR, 0, 4'h0, none, 4'b0100);
    add("str.fetch",    1, I_STR,  1, 4'h0, fet,  4'b0100);
    add("str.decode",   1, I_STR,  1, 4'h0, ctl(0,0,0,0,2'b10,0,0,0,0,2'b00,2'b00,0), 4'b0100);
    add("str.memadr",   1, I_STR,  1, 4'h0, ctl(0,0,0,0,2'b10,0,1,0,0,2'b01,2'b01,0), 4'b0100);
    for (int k = 0; k < 2; k++)
      add($sformatf("str.memwr.wait%0d", k), 1, I_STR, 0, 4'h0,
          ctl(0,0,1,0,2'b10,0,0,1,0,2'b00,2'b00,0), 4'b0100);
    add("str.memwr.rdy", 1, I_STR, 1, 4'h0, ctl(0,0,1,0,2'b10,0,0,1,0,2'b00,2'b00,0), 4'b0100);
    add("cmp1.fetch",   1, I_CMP,  1, 4'h0, fet,  4'b0100);
    add("cmp1.decode",  1, I_CMP,  1, 4'h0, none, 4'b0100);
    add("cmp1.exec",    1, I_CMP,  1, 4'h0, ctl(0,0,0,0,2'b00,0,0,0,0,2'b00,2'b01,0), 4'b0100);
    add("cmp1.aluwb",   1, I_CMP,  1, 4'b0011, ctl(0,0,0,0,2'b00,0,0,0,0,2'b00,2'b01,0), 4'b0100);
    add("ands.fetch",   1, I_ANDS, 1, 4'h0, fet,  4'b0011);
    add("ands.decode",  1, I_ANDS, 1, 4'h0, none, 4'b0011);
    add("ands.exec",    1, I_ANDS, 1, 4'h0, ctl(0,0,0,0,2'b00,0,0,0,0,2'b00,2'b10,0), 4'b0011);
    add("ands.aluwb",   1, I_ANDS, 1, 4'b1000, ctl(0,0,0,0,2'b00,1,0,0,0,2'b00,2'b10,0), 4'b0011);
    add("ill.fetch",    1, I_ILL,  1, 4'h0, fet,  4'b1011);
    add("ill.decode",   1, I_ILL,  1, 4'h0, ctl(0,0,0,0,2'b00,0,0,0,0,2'b00,2'b00,1), 4'b1011);
    add("cmp2.fetch",   1, I_CMP,  1, 4'h0, fet,  4'b1011);
    add("cmp2.decode",  1, I_CMP,  1, 4'h0, none, 4'b1011);
    add("cmp2.exec",    1, I_CMP,  1, 4'h0, ctl(0,0,0,0,2'b00,0,0,0,0,2'b00,2'b01,0), 4'b1011);
    add("cmp2.aluwb",   1, I_CMP,  1, 4'b0100, ctl(0,0,0,0,2'b00,0,0,0,0,2'b00,2'b01,0), 4'b1011);
    add("addgt.fetch",  1, I_ADDGT, 1, 4'h0, fet, 4'b0100);
    add("addgt.decode", 1, I_ADDGT, 1, 4'h0, none, 4'b0100);
    add("orr.fetch",    1, I_ORR,  1, 4'h0, fet,  4'b0100);
    add("orr.decode",   1, I_ORR,  1, 4'h0, none, 4'b0100);
    add("orr.exec",     1, I_ORR,  1, 4'h0, ctl(0,0,0,0,2'b00,0,1,0,0,2'b00,2'b11,0), 4'b0100);
    add("orr.aluwb",    1, I_ORR,  1, 4'hF, ctl(0,0,0,0,2'b00,1,1,0,0,2'b00,2'b11,0), 4'b0100);
    add("idle.fetch",   1, I_ORR,  0, 4'h0, none, 4'b0100);

    // hold reset across two edges so flags are defined before the first row
    reset_n = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clock);

    foreach (tbl[i]) step(tbl[i]);

    // reset asserted while STR is waiting in MEMWR
    tbl.delete();
    add("rst.str.fetch",  1, I_STR, 1, 4'h0, fet, 4'b0100);
    add("rst.str.decode", 1, I_STR, 1, 4'h0, ctl(0,0,0,0,2'b10,0,0,0,0,2'b00,2'b00,0), 4'b0100);
    add("rst.str.memadr", 1, I_STR, 1, 4'h0, ctl(0,0,0,0,2'b10,0,1,0,0,2'b01,2'b01,0), 4'b0100);
    add("rst.str.memwr",  1, I_STR, 0, 4'h0, ctl(0,0,1,0,2'b10,0,0,1,0,2'b00,2'b00,0), 4'b0100);
    add("rst.assert",     0, I_STR, 0, 4'h0, none, 4'b0100);
    add("rst.after.wait", 1, I_STR, 0, 4'h0, none, 4'b0000);
    add("rst.after.fetch", 1, I_ADD, 1, 4'h0, fet, 4'b0000);
    add("rst.after.decode", 1, I_ADD, 1, 4'h0, none, 4'b0000);
    foreach (tbl[i]) step(tbl[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arm_mc_control.md
# arm_mc_control

Multi-cycle control unit for the ARM-subset `DataPath`, successor to the fixed control vectors currently driven by hand from the bench. It decodes `Instr`, sequences each instruction over several cycles through an explicit FSM, and holds an architectural NZCV register. It evaluates ARM condition codes, so every instruction executes conditionally. Memory accesses use a ready handshake, which supports variable-latency instruction and data memory.

## Interface
Parameters:
- `ALUCTRL_W`, 2: width of `ALUControl`.
- `IMMSRC_W`, 2: width of `ImmSrc`.
- `COND_EN`, 1: when 0, every condition field is treated as AL.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  synchronous reset, active-low.
- `Instr`  in  32  instruction word from the datapath.
- `Z`, `N`, `C`, `V`  in  1 each  ALU flags for the current ALU operation.
- `mem_ready`  in  1  memory has completed the current access this cycle.
- `PCWrite`, `IRWrite`, `AdrSrc`  out  1 each  PC load, IR load, address mux select (0 = PC, 1 = ALU result).
- `PCSrc`  out  1  PC input select (0 = PC+4, 1 = ALU result).
- `RegSrc`  out  2  register-address selects, same encoding as the datapath.
- `RegWrite`, `ALUSrc`, `MemWrite`, `MemtoReg`  out  1 each  datapath controls.
- `ImmSrc`  out  `IMMSRC_W`  immediate format (00 = imm8, 01 = imm12, 10 = imm24 branch).
- `ALUControl`  out  `ALUCTRL_W`  00 ADD, 01 SUB, 10 AND, 11 ORR.
- `flags`  out  4  registered {N,Z,C,V}.
- `illegal`  out  1  one-cycle pulse on an unsupported encoding.

## Operation
Instruction fields:
- `cond` = [31:28], `op` = [27:26], `I` = [25], `cmd` = [24:21], `S`/`L` = [20], `U` = [23].
- op 00 is data-processing. Supported `cmd` values: ADD 0100, SUB 0010, AND 0000, ORR 1100, CMP 1010.
  - CMP acts as SUB with S forced to 1 and no register write.
- op 01 is LDR when L=1 and STR when L=0. U=1 adds the offset; U=0 subtracts it.
- op 10 is B.
- Anything else pulses `illegal` in DECODE and returns to FETCH with no writes.

FSM states:
- FETCH: `AdrSrc`=0. Stay until `mem_ready`. In the `mem_ready` cycle assert `IRWrite`, `PCWrite`, `PCSrc`=0.
- DECODE: evaluate the condition against `flags`. On fail go to FETCH. Otherwise dispatch to EXEC, MEMADR or BRANCH.
- EXEC: drive `ALUSrc`=`I`, ImmSrc 00, the `ALUControl` for `cmd`, then go to ALUWB.
- ALUWB: `RegWrite`=1 unless CMP. If S, load `flags`:
  - ADD/SUB/CMP load all four flags.
  - AND/ORR load N and Z only; C and V are held.
  - Then go to FETCH.
- MEMADR: `ALUSrc`=1, ImmSrc 01, ADD or SUB per U. Go to MEMRD for LDR, MEMWR for STR.
- MEMRD: `AdrSrc`=1. Wait for `mem_ready`, then go to MEMWB.
- MEMWB: `MemtoReg`=1, `RegWrite`=1, then go to FETCH.
- MEMWR: `AdrSrc`=1, `MemWrite`=1 every cycle until `mem_ready`, then go to FETCH.
- BRANCH: ImmSrc 10, `ALUSrc`=1, ADD, `PCSrc`=1, `PCWrite`=1, then go to FETCH.

Conditions:
- All 15 ARM conditions EQ through AL are decoded from the registered `flags`.
- cond 1111 is treated as illegal.

## Timing
- Reset: a cycle with `reset_n`=0 at the edge forces state to FETCH and `flags` to 0000. All outputs are 0 while in reset and in the first FETCH cycle until `mem_ready`.
- Reset mid-instruction aborts the instruction with no register, flag or memory write at that edge.
- Outputs are Moore, decoded from the state and the registered IR fields. The exceptions are `IRWrite`/`PCWrite` in FETCH and the exit conditions of the wait states, which also depend on `mem_ready`.
- Minimum cycles with `mem_ready` held at 1:
  - data-processing: 4
  - LDR: 5
  - STR: 4
  - B: 3
  - condition fail or illegal: 2
- Each cycle that `mem_ready` is low adds exactly one cycle to FETCH, MEMRD or MEMWR.
- `flags` updates at the ALUWB edge. The next instruction's DECODE sees the new value.

## Structure
- Package `arm_ctrl_pkg` holds:
  - the state enum
  - `ALUControl` constants
  - ImmSrc constants
  - cmd and op encodings
  - condition-code constants
- Sub-module `cond_check` is purely combinational: (`cond`, `flags`, `COND_EN`) -> pass.
- The FSM and decode stay in `arm_mc_control`.

## Test plan
- Reset, then `mem_ready`=1 with ADD r1,r2,r3 (0xE0821003): FETCH→DECODE→EXEC→ALUWB. `ALUControl`=00, `RegWrite`=1 only in ALUWB, 4 cycles, `flags` unchanged.
- SUBS with Z=1 returned, then BNE (0x1AFFFFFE): `flags`=0100. BNE fails at DECODE and returns to FETCH after 2 cycles with no `PCWrite` beyond the fetch.
- LDR with `mem_ready` low for 3 cycles in MEMRD: the instruction takes 8 cycles. `MemtoReg`=`RegWrite`=1 exactly once. `AdrSrc`=1 throughout MEMRD.
- STR: `MemWrite` stays high until the `mem_ready` cycle and then drops. `RegWrite` is never asserted.
- ANDS with C=1, V=1 and prior `flags`=0011: N and Z update while C and V stay 11. CMP updates all four flags with `RegWrite`=0.
- `reset_n` low during MEMWR: no `MemWrite` at the next edge, state goes to FETCH, `flags`=0000. Illegal op 11 pulses `illegal` for 1 cycle.
